// File: rtl/dipsw_debouncer.sv
// dipsw_debouncer: two-flop synchronizer plus per-bit stability counter
// for the DIP switch bank feeding the comparator operands.
module dipsw_debouncer #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 160000,
  parameter int CNT_WIDTH       = 18
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic             changed,
  output logic             busy
);

  localparam longint CNT_LIMIT = longint'(1) << CNT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX =
    CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Reject parameter sets the counter cannot represent.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (longint'(DEBOUNCE_CYCLES - 1) >= CNT_LIMIT) begin : g_bad_width
    $error("CNT_WIDTH too small for DEBOUNCE_CYCLES");
  end

  logic [WIDTH-1:0]     s1;
  logic [WIDTH-1:0]     s2;
  logic [CNT_WIDTH-1:0] cnt     [WIDTH];
  logic [CNT_WIDTH-1:0] cnt_nxt [WIDTH];
  logic [WIDTH-1:0]     stable_nxt;
  logic [WIDTH-1:0]     upd;
  logic                 busy_nxt;

  // Per-bit counter rule: clear on match, commit at the limit, else count.
  always_comb begin
    stable_nxt = sw_stable;
    upd        = '0;
    busy_nxt   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] == sw_stable[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        stable_nxt[i] = s2[i];
        upd[i]        = 1'b1;
        cnt_nxt[i]    = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + CNT_WIDTH'(1);
      end
      busy_nxt = busy_nxt | (cnt_nxt[i] != '0);
    end
  end

  // Synchronizer, counters and registered outputs; reset wins.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1        <= '0;
      s2        <= '0;
      sw_stable <= '0;
      changed   <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1        <= sw_raw;
      s2        <= s1;
      sw_stable <= stable_nxt;
      changed   <= |upd;
      busy      <= busy_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

endmodule

// File: doc/dipsw_debouncer.md
# dipsw_debouncer

Synchronizes and debounces the raw DIP switch bank before the comparator consumes it. Each switch bit passes through a two-flop synchronizer and its own stability counter, so the comparator's `a`/`b` operands only change after a switch has held a new level for a programmable number of clocks. The block also flags operand updates with a one-cycle strobe, which downstream status logic uses. Top level instantiates it between the `DIPSW` pins and the comparator inputs.

## Interface

**Parameters**
- `WIDTH`, default 8: number of switch bits. The top-level operand split uses bits [7:4] and [3:0].
- `DEBOUNCE_CYCLES`, default 160000: number of consecutive cycles a new level must persist. This is 10 ms at 16 MHz. Legal values are ≥ 2.
- `CNT_WIDTH`, default 18: counter width. It must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES−1. Elaboration fails otherwise.

**Ports**
- `CLK`, input, 1: system clock, 16 MHz board oscillator. This is the only clock.
- `RST`, input, 1: synchronous, active-high reset.
- `sw_raw`, input, WIDTH: asynchronous switch levels, direct from pins.
- `sw_stable`, output, WIDTH: debounced levels. Bit i corresponds to `sw_raw[i]`.
- `changed`, output, 1: one-cycle pulse, high in the first cycle `sw_stable` shows a new value.
- `busy`, output, 1: high while any bit's counter is nonzero, i.e. a transition is pending.

## Operation

**Per-bit pipeline**
- Two synchronizer stages: `s1[i] <= sw_raw[i]`, then `s2[i] <= s1[i]`.
- Each bit has a `CNT_WIDTH` counter `cnt[i]`.

**Per-bit counter rule, evaluated every rising edge when RST is low**
- If `s2[i] == sw_stable[i]`: `cnt[i] <= 0`.
- Else if `cnt[i] == DEBOUNCE_CYCLES−1`: `sw_stable[i] <= s2[i]` and `cnt[i] <= 0`.
- Else: `cnt[i] <= cnt[i] + 1`.
- The counter never wraps. Its maximum reachable value is DEBOUNCE_CYCLES−1.

**Bit independence**
- Bits are fully independent. No bit's counter affects another.

**`changed` strobe**
- `changed` is registered. It is set for exactly one cycle on any edge where at least one `sw_stable` bit updates.
- Multiple bits updating on the same edge produce a single pulse.
- Updates on consecutive edges produce `changed` high on both cycles.

**`busy` output**
- `busy` is the registered OR of (`cnt[i] != 0`) across all bits, using the next-state counter values.
- It therefore aligns with the counters' post-edge state.

**Reset**
- While RST is high at a rising edge, the following all go to 0: `s1`, `s2`, every `cnt`, `sw_stable`, `changed`, and `busy`.
- Reset asserted mid-count discards the pending transition; no partial count survives.
- After reset, any switch held high takes the full latency below to appear. `changed` pulses when it does.

## Timing

**Latency**
- Edge E0 is the first rising edge at which `sw_raw[i]` shows a new level that then holds.
- `s2[i]` shows the new level after edge E1.
- `cnt[i]` counts on edges E2 through E(DEBOUNCE_CYCLES).
- `sw_stable[i]` and `changed` update on edge E(DEBOUNCE_CYCLES+1). The same edge drops `busy`, unless another bit is pending.

**Glitch rejection**
- A new level held for DEBOUNCE_CYCLES−1 or fewer samples at `s2` is rejected. The counter clears on the first matching sample, and `sw_stable` and `changed` do not move.

**Bounce**
- Any return to the stable level restarts the count from 0.
- The required persistence is consecutive, not cumulative.

**Output behaviour**
- Outputs change only on rising edges of `CLK`.
- `sw_stable` is glitch-free and holds its value between updates.

**Concurrent reset**
- RST has priority over all counter and update logic on the same edge.

## Test plan

Run all scenarios with `DEBOUNCE_CYCLES=4` and `WIDTH=8`.

1. **Reset values.** Hold RST for 3 cycles with `sw_raw=8'hFF`, then release.
   - `sw_stable=0`, `changed=0`, and `busy=0` during reset.
   - `busy=1` from the second edge after release.
   - `sw_stable=8'hFF` with a one-cycle `changed` pulse on edge E5 after release.
2. **Clean single-bit change.** From stable 8'h00, set `sw_raw[3]=1` before E0.
   - `sw_stable=8'h08` and `changed=1` after E5 only.
   - `changed=0` after E6.
3. **Glitch rejection.** Pulse `sw_raw[0]=1` for exactly 3 cycles.
   - `sw_stable` stays 8'h00 and `changed` never asserts.
   - `busy` rises, then falls after the counter clears.
4. **Bounce restart.** Drive `sw_raw[7]` in the pattern 1,1,0,1,1,1,1 (one value per cycle).
   - The update occurs 5 edges after the final rising transition, not after the first.
5. **Simultaneous bits.** Change 8'h00 to 8'hA5 on one edge.
   - A single `changed` pulse, with `sw_stable=8'hA5` on E5.
   - Then change `sw_raw[1]` one cycle after `sw_raw[0]`: two consecutive `changed` pulses, each bit updating on its own E5.
6. **Reset mid-count.** Assert RST at cycle 3 of a pending transition to 8'h0F.
   - All outputs are 0 after the reset edge.
   - After release, the full 5-edge latency applies again.
